// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter sharing one single-ported memory
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM_I = 2'd1,
        MEM_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q, state_n;
    logic [3:0]        starve_q, starve_n;
    logic              m_req_q, m_req_n;
    logic              m_we_q, m_we_n;
    logic [ADDR_W-1:0] m_addr_q, m_addr_n;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_n;
    logic              i_ack_q, i_ack_n;
    logic              d_ack_q, d_ack_n;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_n;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_n;
    logic              busy_q, busy_n;
    logic              grant_d, grant_i;

    // Data wins unless fetch has waited through STARVE_MAX consecutive data grants.
    always_comb begin
        grant_d = d_req && !(i_req && (starve_q == STARVE_LIM));
        grant_i = i_req && !grant_d;
    end

    always_comb begin
        state_n   = state_q;
        starve_n  = starve_q;
        m_req_n   = m_req_q;
        m_we_n    = m_we_q;
        m_addr_n  = m_addr_q;
        m_wdata_n = m_wdata_q;
        i_ack_n   = 1'b0;
        d_ack_n   = 1'b0;
        i_rdata_n = i_rdata_q;
        d_rdata_n = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    m_req_n   = 1'b1;
                    m_we_n    = d_we;
                    m_addr_n  = d_addr;
                    m_wdata_n = d_wdata;
                    state_n   = MEM_D;
                    if (!i_req)
                        starve_n = 4'd0;
                    else if (starve_q != STARVE_LIM)
                        starve_n = starve_q + 4'd1;
                end else if (grant_i) begin
                    m_req_n   = 1'b1;
                    m_we_n    = 1'b0;
                    m_addr_n  = i_addr;
                    m_wdata_n = '0;
                    starve_n  = 4'd0;
                    state_n   = MEM_I;
                end
            end
            MEM_I: begin
                if (m_ready) begin
                    i_rdata_n = m_rdata;
                    i_ack_n   = 1'b1;
                    m_req_n   = 1'b0;
                    m_we_n    = 1'b0;
                    state_n   = RESP;
                end
            end
            MEM_D: begin
                if (m_ready) begin
                    d_rdata_n = m_rdata;
                    d_ack_n   = 1'b1;
                    m_req_n   = 1'b0;
                    m_we_n    = 1'b0;
                    state_n   = RESP;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // Asynchronous reset also aborts an in-flight access: m_req falls without an ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            starve_q  <= 4'd0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            starve_q  <= starve_n;
            m_req_q   <= m_req_n;
            m_we_q    <= m_we_n;
            m_addr_q  <= m_addr_n;
            m_wdata_q <= m_wdata_n;
            i_ack_q   <= i_ack_n;
            d_ack_q   <= d_ack_n;
            i_rdata_q <= i_rdata_n;
            d_rdata_q <= d_rdata_n;
            busy_q    <= busy_n;
        end
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = busy_q;

endmodule
